// File: rtl/if_id_fetch_queue_pkg.sv
// Shared front-end definitions used by fetch, the IF/ID queue and decode.
//   IF_WORD        : PC / instruction width
//   IF_EXCP_W      : fetch exception code width (0 = no exception)
//   IF_PC_RST_VAL  : PC shown to decode when nothing is queued or in reset
//   IF_NOP_INST    : instruction shown to decode when nothing is queued
//   EXCP_*         : fetch exception codes carried alongside each entry
package if_id_fetch_queue_pkg;

    localparam int IF_WORD   = 32;
    localparam int IF_EXCP_W = 6;

    localparam logic [IF_WORD-1:0] IF_PC_RST_VAL = 32'h1c00_0000;
    // andi r0, r0, 0
    localparam logic [IF_WORD-1:0] IF_NOP_INST   = 32'h0340_0000;

    localparam logic [IF_EXCP_W-1:0] EXCP_NONE = 6'h00;
    localparam logic [IF_EXCP_W-1:0] EXCP_PIF  = 6'h03;
    localparam logic [IF_EXCP_W-1:0] EXCP_PPI  = 6'h07;
    localparam logic [IF_EXCP_W-1:0] EXCP_ADEF = 6'h08;
    localparam logic [IF_EXCP_W-1:0] EXCP_TLBR = 6'h3f;

endpackage

// File: rtl/if_id_fetch_queue_sync_fifo_flushable.sv
// Generic synchronous FIFO with occupancy count and single-cycle clear.
//   clk, rst              : clock, synchronous active-high reset
//   clear                 : drop all entries at the next edge; blocks push/pop
//   push_valid/ready/data : write side handshake
//   pop_valid/ready/data  : read side handshake, pop_data is the head entry
//   count                 : number of stored entries
// push_ready is full-based only; a pop in the same cycle does not free a slot
// for a push, so there is no combinational path from pop_ready to push_ready.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module sync_fifo_flushable #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign push_ready = (count != CNT_W'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push       = push_valid & push_ready & ~clear;
    assign pop        = pop_valid & pop_ready & ~clear;
    assign pop_data   = mem[rd_ptr];

    // Storage is never reset; the owner masks the head when count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID instruction queue between fetch and decode.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : one bit per flush source; any bit empties the queue
//   in_valid/in_ready : fetch handshake; in_pc, in_inst, in_pred_taken,
//                       in_pred_target, in_excp form one entry
//   out_valid/out_ready : decode handshake; out_* present the head entry
//   count             : occupancy
// With the queue empty, decode sees a NOP at PC_RST_VAL with no prediction
// and no exception, so stale storage never leaks into decode. There is no
// fall-through: an entry pushed at one edge appears after that edge.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int                WORD       = IF_WORD,
    parameter int                DEPTH      = 4,
    parameter int                FLUSH_SRC  = 3,
    parameter int                EXCP_W     = IF_EXCP_W,
    parameter logic [WORD-1:0]   PC_RST_VAL = IF_PC_RST_VAL,
    parameter logic [WORD-1:0]   NOP_INST   = IF_NOP_INST,
    localparam int               CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUSH_SRC-1:0] flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD-1:0]      in_pc,
    input  logic [WORD-1:0]      in_inst,
    input  logic                 in_pred_taken,
    input  logic [WORD-1:0]      in_pred_target,
    input  logic [EXCP_W-1:0]    in_excp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      out_pc,
    output logic [WORD-1:0]      out_inst,
    output logic                 out_pred_taken,
    output logic [WORD-1:0]      out_pred_target,
    output logic [EXCP_W-1:0]    out_excp,
    output logic [CNT_W-1:0]     count
);

    localparam int ENTRY_W = 3 * WORD + 1 + EXCP_W;

    logic               flush_any;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               head_valid;
    logic [WORD-1:0]    head_pc;
    logic [WORD-1:0]    head_inst;
    logic               head_pred_taken;
    logic [WORD-1:0]    head_pred_target;
    logic [EXCP_W-1:0]  head_excp;

    assign flush_any = |flush;
    assign wr_entry  = {in_pc, in_inst, in_pred_taken, in_pred_target, in_excp};

    sync_fifo_flushable #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush_any),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (wr_entry),
        .pop_valid  (head_valid),
        .pop_ready  (out_ready),
        .pop_data   (rd_entry),
        .count      (count)
    );

    assign {head_pc, head_inst, head_pred_taken, head_pred_target, head_excp} = rd_entry;

    always_comb begin
        out_valid       = head_valid;
        out_pc          = PC_RST_VAL;
        out_inst        = NOP_INST;
        out_pred_taken  = 1'b0;
        out_pred_target = '0;
        out_excp        = '0;
        if (head_valid) begin
            out_pc          = head_pc;
            out_inst        = head_inst;
            out_pred_taken  = head_pred_taken;
            out_pred_target = head_pred_target;
            out_excp        = head_excp;
        end
    end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry instruction queue between fetch (IF1) and decode (ID), using a valid/ready handshake on both sides.
- Carries PC, instruction word, branch-prediction metadata and fetch-exception code per entry.
- Decouples ICache/fetch bubbles from decode stalls; a one-hot multi-source flush empties the queue in one cycle.

Parameters:
- WORD, 32, PC/instruction width.
- DEPTH, 4, number of entries; power of two, >= 2.
- FLUSH_SRC, 3, number of flush request inputs (EX branch, ICache, predecoder branch).
- EXCP_W, 6, fetch exception code width; 0 means no exception.
- PC_RST_VAL, 32'h1c000000, PC presented when the queue is empty or in reset.
- NOP_INST, 32'h03400000, instruction presented when empty (andi r0,r0,0).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  FLUSH_SRC  flush requests, any bit set = flush
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue can accept this cycle
- in_pc  in  WORD  fetch PC
- in_inst  in  WORD  fetched instruction
- in_pred_taken  in  1  predictor taken bit
- in_pred_target  in  WORD  predicted target
- in_excp  in  EXCP_W  fetch exception code
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head (low = decode/load-use/DCache stall)
- out_pc  out  WORD  head PC
- out_inst  out  WORD  head instruction
- out_pred_taken  out  1  head prediction
- out_pred_target  out  WORD  head predicted target
- out_excp  out  EXCP_W  head exception code
- count  out  clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0. In that and the following cycles: out_valid=0, in_ready=1, out_pc=PC_RST_VAL, out_inst=NOP_INST, out_pred_taken=0, out_pred_target=0, out_excp=0.
- Reset dominates flush and push. Reset mid-traffic discards all entries.
- Push = in_valid & in_ready & ~flush_any. Entry written at wr_ptr; wr_ptr increments mod DEPTH.
- Pop = out_valid & out_ready & ~flush_any. rd_ptr increments mod DEPTH.
- in_ready = (count != DEPTH). It does not depend on out_ready: no push into a full queue even if a pop occurs the same cycle. This keeps the decode-to-fetch path combinationally free.
- count' = count + push - pop. A simultaneous push and pop leaves count unchanged.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (1-cycle IF-to-ID, same as the previous single register).
- out_* are combinational from the head storage entry when count != 0. When count == 0, out_* show the empty values listed under reset. There is no fall-through from in_* to out_*.
- Flush: flush_any = |flush. At the edge, wr_ptr=rd_ptr=0 and count=0. Any push or pop in that cycle is dropped. Flush has priority over every handshake.
- Flush and stall in the same cycle: flush wins. This matches the old rule that a branch flush overrides a load stall.
- Storage contents are never cleared except by overwrite. The empty-output muxing guarantees no stale data reaches decode.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are distinguished only by count.
- Data is stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package/header holds WORD, PC_RST_VAL, NOP_INST and the EXCP_W codes, reused by the fetch and decode stages.
- One natural sub-module: sync_fifo_flushable. It is a generic width/depth FIFO with count and single-cycle clear.
- if_id_fetch_queue wraps it and adds:
  - packing/unpacking of {pc, inst, pred_taken, pred_target, excp};
  - the flush OR-reduction;
  - the empty-output muxing.

Test Plan:
- Reset then idle -> out_valid=0, out_pc=0x1c000000, out_inst=0x03400000, count=0, in_ready=1.
- Push PC 0x1c000000..0x1c00000c with out_ready=0 -> count=4, in_ready=0. A 5th push with in_valid=1 is not accepted. Then out_ready=1 for 4 cycles -> outputs 0x1c000000, 04, 08, 0c in order, then out_valid=0.
- Continuous push+pop with out_ready=1 for 10 entries (pointers wrap twice) -> count holds at 1, every PC emitted exactly once in order, no gaps.
- Queue holds 3 entries, flush=3'b100 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the pushed entry is absent.
- Decode stall: out_ready=0 for 5 cycles with count=2 -> out_pc/out_inst/out_pred_target unchanged every cycle. An entry pushed with in_excp=6'h08, in_pred_taken=1, target 0x1c000100 is emitted with the same values.
- rst asserted while count=3 and flush=1 -> next cycle all outputs at reset values and count=0.
